// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receiver front end.
package uart_rx_pkg;

  localparam int unsigned EDGE_W  = 6;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned PRESC_W = 6;

  localparam logic [PRESC_W-1:0] PRESC_4       = PRESC_W'(4);
  localparam logic [PRESC_W-1:0] PRESC_8       = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] PRESC_16      = PRESC_W'(16);
  localparam logic [PRESC_W-1:0] PRESC_32      = PRESC_W'(32);
  localparam logic [PRESC_W-1:0] PRESC_DEFAULT = PRESC_8;

  function automatic logic presc_legal(input logic [PRESC_W-1:0] p);
    return (p == PRESC_4) || (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Prescale latch, oversample edge counter and saturating frame bit counter.
module uart_rx_edge_bit_cnt #(
  parameter int unsigned EDGE_W  = uart_rx_pkg::EDGE_W,
  parameter int unsigned BIT_W   = uart_rx_pkg::BIT_W,
  parameter int unsigned PRESC_W = uart_rx_pkg::PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic [PRESC_W-1:0] presc_o,
  output logic [EDGE_W-1:0]  edge_cnt_o,
  output logic [BIT_W-1:0]   bit_cnt_o,
  output logic               prescale_err_o
);
  import uart_rx_pkg::*;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               err_q, err_d;

  // Prescale only follows the input while idle so a frame keeps one bit period.
  always_comb begin
    presc_d = presc_q;
    err_d   = err_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    if (!enable_i) begin
      edge_d = '0;
      bit_d  = '0;
      if (presc_legal(prescale_i)) begin
        presc_d = prescale_i;
        err_d   = 1'b0;
      end else begin
        presc_d = PRESC_DEFAULT;
        err_d   = 1'b1;
      end
    end else if (edge_q == EDGE_W'(presc_q - PRESC_W'(1))) begin
      edge_d = '0;
      if (bit_q != {BIT_W{1'b1}}) begin
        bit_d = bit_q + BIT_W'(1);
      end
    end else begin
      edge_d = edge_q + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= PRESC_DEFAULT;
      err_q   <= 1'b0;
      edge_q  <= '0;
      bit_q   <= '0;
    end else begin
      presc_q <= presc_d;
      err_q   <= err_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
    end
  end

  assign presc_o        = presc_q;
  assign edge_cnt_o     = edge_q;
  assign bit_cnt_o      = bit_q;
  assign prescale_err_o = err_q;

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front end: counters plus 3-point mid-bit majority sampler.
// Define UART_RX_SYNC_EN to insert a 2-flop synchroniser on RX_IN.
module uart_rx_edge_bit_sampler #(
  parameter int unsigned EDGE_W  = uart_rx_pkg::EDGE_W,
  parameter int unsigned BIT_W   = uart_rx_pkg::BIT_W,
  parameter int unsigned PRESC_W = uart_rx_pkg::PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic               enable,
  input  logic               dat_samp_en,
  input  logic [PRESC_W-1:0] prescale,
  output logic [EDGE_W-1:0]  edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sampled_bit,
  output logic               samp_valid,
  output logic               prescale_err
);
  import uart_rx_pkg::*;

  logic [PRESC_W-1:0] presc;
  logic [EDGE_W-1:0]  half;
  logic               rx_s;
  logic               s0_q, s0_d;
  logic               s1_q, s1_d;
  logic               bit_q, bit_d;
  logic               valid_q, valid_d;

  uart_rx_edge_bit_cnt #(
    .EDGE_W (EDGE_W),
    .BIT_W  (BIT_W),
    .PRESC_W(PRESC_W)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .prescale_i    (prescale),
    .presc_o       (presc),
    .edge_cnt_o    (edge_cnt),
    .bit_cnt_o     (bit_cnt),
    .prescale_err_o(prescale_err)
  );

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = RX_IN;
`endif

  assign half = EDGE_W'(presc >> 1);

  // Samples at half-1 and half; vote on the third at half+1.
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (enable && dat_samp_en) begin
      if (edge_cnt == half - EDGE_W'(1)) begin
        s0_d = rx_s;
      end
      if (edge_cnt == half) begin
        s1_d = rx_s;
      end
      if (edge_cnt == half + EDGE_W'(1)) begin
        bit_d   = maj3(s0_q, s1_q, rx_s);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

  assign sampled_bit = bit_q;
  assign samp_valid  = valid_q;

endmodule
